baccarat_deal_ctrl: RTL and testbench

BACCARAT_DEAL_CTRL -- requirements
Module: baccarat_deal_ctrl

---
 rtl/baccarat_deal_ctrl_if.sv | 27 ++
 rtl/baccarat_deal_ctrl.sv | 147 ++++++++++++++
 tb/tb_baccarat_deal_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/baccarat_deal_ctrl_if.sv
// Handshake bundle between the baccarat deal controller and the card datapath.
// The controller takes the slave view; the datapath/stimulus side takes the master view.
interface baccarat_deal_ctrl_if;
    logic       start;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;
    logic       busy;
    logic       done;

    modport master (
        output start, pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light, busy, done
    );

    modport slave (
        input  start, pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light, busy, done
    );
endinterface

// File: rtl/baccarat_deal_ctrl.sv
// Baccarat round sequencer: deals four cards, applies the third-card tableau,
// lights the winner for HOLD_CYCLES slowclock cycles and pulses done.
module baccarat_deal_ctrl #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic               slowclock,
    input  logic               resetb,
    baccarat_deal_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, P1, D1, P2, D2, SETTLE, CHECK, P3, P3_SETTLE,
        DDECIDE, D3, D3_SETTLE, RESULT, HOLD
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] ps_q, ds_q;
    logic       from_d3;
    logic [3:0] res_ps, res_ds;

    // Banker tableau once the player has taken a third card.
    function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] pc3);
        case (ds)
            4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
            4'd3:             dealer_draws = (pc3 != 4'd8);
            4'd4:             dealer_draws = (pc3 >= 4'd2) && (pc3 <= 4'd7);
            4'd5:             dealer_draws = (pc3 >= 4'd4) && (pc3 <= 4'd7);
            4'd6:             dealer_draws = (pc3 >= 4'd6) && (pc3 <= 4'd7);
            default:          dealer_draws = 1'b0;
        endcase
    endfunction

    // Scores are only valid right after a settle cycle; RESULT following D3_SETTLE
    // is such a cycle, otherwise it uses the copy taken in CHECK/DDECIDE.
    always_comb begin
        res_ps = from_d3 ? bus.pscore : ps_q;
        res_ds = from_d3 ? bus.dscore : ds_q;
    end

    always_ff @(posedge slowclock or negedge resetb) begin
        if (!resetb) begin
            state                <= IDLE;
            cnt                  <= '0;
            ps_q                 <= '0;
            ds_q                 <= '0;
            from_d3              <= 1'b0;
            bus.load_pcard1      <= 1'b0;
            bus.load_pcard2      <= 1'b0;
            bus.load_pcard3      <= 1'b0;
            bus.load_dcard1      <= 1'b0;
            bus.load_dcard2      <= 1'b0;
            bus.load_dcard3      <= 1'b0;
            bus.player_win_light <= 1'b0;
            bus.dealer_win_light <= 1'b0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
        end else begin
            bus.load_pcard1 <= 1'b0;
            bus.load_pcard2 <= 1'b0;
            bus.load_pcard3 <= 1'b0;
            bus.load_dcard1 <= 1'b0;
            bus.load_dcard2 <= 1'b0;
            bus.load_dcard3 <= 1'b0;
            bus.done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state           <= P1;
                        bus.load_pcard1 <= 1'b1;
                        bus.busy        <= 1'b1;
                        from_d3         <= 1'b0;
                    end
                end
                P1: begin
                    state           <= D1;
                    bus.load_dcard1 <= 1'b1;
                end
                D1: begin
                    state           <= P2;
                    bus.load_pcard2 <= 1'b1;
                end
                P2: begin
                    state           <= D2;
                    bus.load_dcard2 <= 1'b1;
                end
                D2:     state <= SETTLE;
                SETTLE: state <= CHECK;
                CHECK: begin
                    ps_q <= bus.pscore;
                    ds_q <= bus.dscore;
                    if (bus.pscore >= 4'd8 || bus.dscore >= 4'd8) begin
                        state <= RESULT;
                    end else if (bus.pscore <= 4'd5) begin
                        state           <= P3;
                        bus.load_pcard3 <= 1'b1;
                    end else if (bus.dscore <= 4'd5) begin
                        state           <= D3;
                        bus.load_dcard3 <= 1'b1;
                    end else begin
                        state <= RESULT;
                    end
                end
                P3:        state <= P3_SETTLE;
                P3_SETTLE: state <= DDECIDE;
                DDECIDE: begin
                    ps_q <= bus.pscore;
                    ds_q <= bus.dscore;
                    if (dealer_draws(bus.dscore, bus.pcard3)) begin
                        state           <= D3;
                        bus.load_dcard3 <= 1'b1;
                    end else begin
                        state <= RESULT;
                    end
                end
                D3: state <= D3_SETTLE;
                D3_SETTLE: begin
                    state   <= RESULT;
                    from_d3 <= 1'b1;
                end
                RESULT: begin
                    bus.player_win_light <= (res_ps >= res_ds);
                    bus.dealer_win_light <= (res_ds >= res_ps);
                    cnt                  <= 8'(HOLD_CYCLES - 1);
                    bus.done             <= (HOLD_CYCLES == 1);
                    state                <= HOLD;
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        state                <= IDLE;
                        bus.player_win_light <= 1'b0;
                        bus.dealer_win_light <= 1'b0;
                        bus.busy             <= 1'b0;
                    end else begin
                        cnt      <= cnt - 8'd1;
                        bus.done <= (cnt == 8'd1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// Directed bench for baccarat_deal_ctrl: rounds covering naturals, third-card
// rules, ties, unclamped scores, ignored start and mid-round reset.
module tb_baccarat_deal_ctrl;

    localparam int HOLD = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    baccarat_deal_ctrl_if bus ();

    baccarat_deal_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .slowclock (clk),
        .resetb    (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_lp1, n_ld1, n_lp2, n_ld2, n_lp3, n_ld3, multi, first_lp1;
    int lat, p_lit, d_lit, n_done, done_k, last_lit, ended, idle_act;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2, bus.load_dcard2,
                bus.load_pcard3, bus.load_dcard3, bus.player_win_light,
                bus.dealer_win_light, bus.busy, bus.done};
    endfunction

    function automatic int n_strobes();
        return int'(bus.load_pcard1) + int'(bus.load_dcard1) + int'(bus.load_pcard2) +
               int'(bus.load_dcard2) + int'(bus.load_pcard3) + int'(bus.load_dcard3);
    endfunction

    // The bench plays the card datapath: a third-card strobe updates that hand's score.
    task automatic run_round(input logic [3:0] ps, ds, pc3, ps_after, ds_after, input bit poke);
        bit poked = 1'b0;
        n_lp1 = 0; n_ld1 = 0; n_lp2 = 0; n_ld2 = 0; n_lp3 = 0; n_ld3 = 0;
        multi = 0; first_lp1 = 0; lat = -1; p_lit = 0; d_lit = 0;
        n_done = 0; done_k = -1; last_lit = -2; ended = 0; idle_act = 0;
        bus.pscore = ps; bus.dscore = ds; bus.pcard3 = pc3;
        bus.start  = 1'b1;
        for (int k = 1; k <= 100 && ended == 0; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (n_strobes() > 1) multi++;
            if (bus.load_pcard1) begin n_lp1++; if (first_lp1 == 0) first_lp1 = k; end
            if (bus.load_dcard1) n_ld1++;
            if (bus.load_pcard2) n_lp2++;
            if (bus.load_dcard2) n_ld2++;
            if (bus.load_pcard3) begin n_lp3++; bus.pscore = ps_after; end
            if (bus.load_dcard3) begin n_ld3++; bus.dscore = ds_after; end
            if (bus.player_win_light || bus.dealer_win_light) begin
                if (lat < 0) lat = k - 1;
                last_lit = k;
                if (poke && !poked) begin bus.start = 1'b1; poked = 1'b1; end
            end
            if (bus.player_win_light) p_lit++;
            if (bus.dealer_win_light) d_lit++;
            if (bus.done) begin n_done++; done_k = k; end
            if (!bus.busy) ended = 1;
        end
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.busy || n_strobes() != 0 || bus.done) idle_act++;
        end
    endtask

    task automatic check_round(input string nm, input int e_lp3, e_ld3, e_pw, e_dw, e_lat);
        chk({nm, ".ended"}, ended, 1);
        chk({nm, ".first_lp1"}, first_lp1, 1);
        chk({nm, ".deal"}, n_lp1 + n_ld1 + n_lp2 + n_ld2, 4);
        chk({nm, ".lp3"}, n_lp3, e_lp3);
        chk({nm, ".ld3"}, n_ld3, e_ld3);
        chk({nm, ".multi"}, multi, 0);
        chk({nm, ".latency"}, lat, e_lat);
        chk({nm, ".p_lit"}, p_lit, e_pw * HOLD);
        chk({nm, ".d_lit"}, d_lit, e_dw * HOLD);
        chk({nm, ".done_cnt"}, n_done, 1);
        chk({nm, ".done_last"}, done_k, last_lit);
        chk({nm, ".idle_after"}, idle_act, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.pscore = '0; bus.dscore = '0; bus.pcard3 = '0;
        #1 rst_n = 1'b0;
        #1 chk("reset_outs", int'(outs()), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run_round(4'd8, 4'd3, 4'd0, 4'd8, 4'd3, 1'b0);
        check_round("natural", 0, 0, 1, 0, 7);
        run_round(4'd4, 4'd5, 4'd6, 4'd9, 4'd2, 1'b0);
        check_round("both_draw", 1, 1, 1, 0, 12);
        run_round(4'd2, 4'd3, 4'd8, 4'd5, 4'd3, 1'b0);
        check_round("banker_exc", 1, 0, 1, 0, 10);
        run_round(4'd7, 4'd7, 4'd0, 4'd7, 4'd7, 1'b0);
        check_round("tie", 0, 0, 1, 1, 7);
        run_round(4'd6, 4'd4, 4'd0, 4'd6, 4'd7, 1'b0);
        check_round("dealer_only", 0, 1, 0, 1, 9);
        run_round(4'd3, 4'd7, 4'd6, 4'd1, 4'd7, 1'b0);
        check_round("d7_stands", 1, 0, 0, 1, 10);
        run_round(4'd0, 4'd6, 4'd7, 4'd6, 4'd9, 1'b0);
        check_round("d6_draws", 1, 1, 0, 1, 12);
        run_round(4'd12, 4'd3, 4'd0, 4'd12, 4'd3, 1'b0);
        check_round("unclamped_p", 0, 0, 1, 0, 7);
        run_round(4'd6, 4'd12, 4'd0, 4'd6, 4'd12, 1'b0);
        check_round("unclamped_d", 0, 0, 0, 1, 7);
        run_round(4'd9, 4'd0, 4'd0, 4'd9, 4'd0, 1'b1);
        check_round("start_busy", 0, 0, 1, 0, 7);

        // Abandon a round while the second player card is being loaded.
        bus.pscore = 4'd5; bus.dscore = 4'd5; bus.pcard3 = 4'd0;
        bus.start = 1'b1;
        ended = 0;
        for (int k = 0; k < 20 && ended == 0; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.load_pcard2) ended = 1;
        end
        chk("reach_p2", ended, 1);
        #2 rst_n = 1'b0;
        #1 chk("mid_reset_outs", int'(outs()), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        idle_act = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (outs() != 10'd0) idle_act++;
        end
        chk("post_reset_quiet", idle_act, 0);
        run_round(4'd1, 4'd8, 4'd0, 4'd1, 4'd8, 1'b0);
        check_round("restart", 0, 0, 0, 1, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
